gsr_pulse_gen: RTL

- Source side of the global set/reset path. It merges reset requests into one clean active-low pulse, GSRN, that feeds the GSR input of the device's GSR synchroniser.
- Three request sources:
  - a software four-phase REQ/ACK handshake;
  - a debounced external push-button;
  - loss of clock-lock.
- GSRN is held low for a guaranteed minimum width and is released only once clock-lock is present.

---
 rtl/gsr_pulse_gen_pkg.sv | 22 ++
 rtl/gsr_debounce.sv | 55 +++++
 rtl/gsr_pulse_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/gsr_pulse_gen_pkg.sv
// rtl/gsr_pulse_gen_pkg.sv - shared state and source-flag encodings for the GSR pulse generator
package gsr_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ASSERT    = 2'd1,
    ST_WAIT_LOCK = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_SW   = 2'd1,
    SRC_HW   = 2'd2
  } src_e;

  // GSRN is low and BUSY is high exactly while a sequence is in flight
  function automatic logic in_sequence(state_e s);
    return (s == ST_ASSERT) || (s == ST_WAIT_LOCK);
  endfunction

endpackage

// File: rtl/gsr_debounce.sv
// rtl/gsr_debounce.sv - button synchroniser and debouncer, one PRESS pulse per physical press
module gsr_debounce #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 16
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic BTNN,
  output logic PRESS
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             btn_m_q, btn_s_q;
  logic             pressed_q, pressed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             toward;
  logic             press_d;

  // btn_s is active low, so it matches pressed_q exactly when it points at the opposite level
  assign toward = (btn_s_q == pressed_q);

  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    if (!toward) begin
      cnt_d = '0;
    end else if (cnt_q >= LAST) begin
      pressed_d = ~pressed_q;
      press_d   = ~pressed_q;
      cnt_d     = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign PRESS = press_d;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      btn_m_q   <= 1'b1;
      btn_s_q   <= 1'b1;
      pressed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      btn_m_q   <= BTNN;
      btn_s_q   <= btn_m_q;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/gsr_pulse_gen.sv
// rtl/gsr_pulse_gen.sv - merges software, button and lock-loss requests into one clean GSRN pulse
module gsr_pulse_gen
  import gsr_pulse_gen_pkg::*;
#(
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 16
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic REQ,
  output logic ACK,
  input  logic BTNN,
  input  logic LOCK,
  output logic GSRN,
  output logic BUSY
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  src_e             src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             por_q;
  logic             lock_m_q, lock_s_q, lock_p_q;
  logic             gsrn_q, busy_q, ack_q;
  logic             press, lock_loss, hw_evt;
  state_e           rel_state;
  src_e             rel_src;

  gsr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .CLK  (CLK),
    .RSTN (RSTN),
    .BTNN (BTNN),
    .PRESS(press)
  );

  assign lock_loss = lock_p_q & ~lock_s_q;
  assign hw_evt    = press | lock_loss;
  assign rel_state = (src_q == SRC_SW) ? ST_DONE : ST_IDLE;
  assign rel_src   = (src_q == SRC_SW) ? SRC_SW : SRC_NONE;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          state_d = ST_ASSERT;
          src_d   = SRC_SW;
          cnt_d   = '0;
        end else if (hw_evt) begin
          state_d = ST_ASSERT;
          src_d   = SRC_HW;
          cnt_d   = '0;
        end
      end
      ST_ASSERT: begin
        // por_q holds the count on the first edge after reset so release is a full hold later
        if (hw_evt || por_q) begin
          cnt_d = '0;
        end else if (cnt_q >= HOLD_LAST) begin
          cnt_d = '0;
          if (lock_s_q) begin
            state_d = rel_state;
            src_d   = rel_src;
          end else begin
            state_d = ST_WAIT_LOCK;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (press) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end else if (lock_s_q) begin
          state_d = rel_state;
          src_d   = rel_src;
        end
      end
      ST_DONE: begin
        if (hw_evt) begin
          state_d = ST_ASSERT;
          src_d   = SRC_SW;
          cnt_d   = '0;
        end else if (!REQ) begin
          state_d = ST_IDLE;
          src_d   = SRC_NONE;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q  <= ST_ASSERT;
      src_q    <= SRC_NONE;
      cnt_q    <= '0;
      por_q    <= 1'b1;
      lock_m_q <= 1'b1;
      lock_s_q <= 1'b1;
      lock_p_q <= 1'b1;
      gsrn_q   <= 1'b0;
      busy_q   <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      cnt_q    <= cnt_d;
      por_q    <= 1'b0;
      lock_m_q <= LOCK;
      lock_s_q <= lock_m_q;
      lock_p_q <= lock_s_q;
      gsrn_q   <= ~in_sequence(state_d);
      busy_q   <= in_sequence(state_d);
      ack_q    <= (state_d == ST_DONE);
    end
  end

  assign GSRN = gsrn_q;
  assign BUSY = busy_q;
  assign ACK  = ack_q;

endmodule
